// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out receiver.
package sipo_pkg;

  localparam int SIPO_WIDTH = 4;

  typedef enum bit {
    ORDER_LSB = 1'b0,
    ORDER_MSB = 1'b1
  } bit_order_e;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter: frames serial bits into words and flags completion.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             sync,
  output logic [WIDTH-1:0] word,
  output logic             complete,
  output logic [CW-1:0]    bit_cnt
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
    if (bit_order_e'(MSB_FIRST) == ORDER_MSB) return {s[WIDTH-2:0], b};
    else                                     return {b, s[WIDTH-1:1]};
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (sync) begin
      // Restart framing; a coinciding bit becomes the first bit of the new word.
      sr_d  = '0;
      cnt_d = '0;
      if (bit_en) begin
        sr_d  = shift_in('0, sin);
        cnt_d = CW'(1);
      end
    end else if (bit_en) begin
      sr_d = shift_in(sr_q, sin);
      if (cnt_q == LAST) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The word includes the bit being shifted in on the completion edge.
  assign word    = sr_d;
  assign bit_cnt = cnt_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!clr_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// SIPO receiver top: holding register with valid/ready output and sticky overrun flag.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic [CW-1:0]    bit_cnt,
  output logic             busy
);

  logic [WIDTH-1:0] word;
  logic             complete;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             accept;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk      (clk),
    .clr_n    (clr_n),
    .sin      (sin),
    .bit_en   (bit_en),
    .sync     (sync),
    .word     (word),
    .complete (complete),
    .bit_cnt  (bit_cnt)
  );

  assign accept = valid_q & dout_ready;

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (accept) valid_d = 1'b0;
    if (ovr_clr) ovr_d = 1'b0;
    if (complete) begin
      if (!valid_q || accept) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        // Word dropped behind an unconsumed one; setting wins over a clear.
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the holding register is reset too, so dout reads as zero rather than X before the first word.
    if (!clr_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;
  assign busy       = (bit_cnt != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: LSB-first and MSB-first instances driven with the same serial stream.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       clr_n, sin, bit_en, sync, dout_ready, ovr_clr;
  logic [3:0] dout_l, dout_m;
  logic       valid_l, valid_m, ovr_l, ovr_m, busy_l, busy_m;
  logic [1:0] cnt_l, cnt_m;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clr_n(clr_n), .sin(sin), .bit_en(bit_en), .sync(sync),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .overrun(ovr_l), .ovr_clr(ovr_clr), .bit_cnt(cnt_l), .busy(busy_l)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clr_n(clr_n), .sin(sin), .bit_en(bit_en), .sync(sync),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .overrun(ovr_m), .ovr_clr(ovr_clr), .bit_cnt(cnt_m), .busy(busy_m)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One qualified bit on the next edge; sin is driven to X once bit_en drops.
  task automatic bit_step(input logic b);
    sin    = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    sin    = 1'bx;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) bit_step(w[i]);
  endtask

  initial begin
    clr_n = 1'b0; sin = 1'b0; bit_en = 1'b0; sync = 1'b0;
    dout_ready = 1'b0; ovr_clr = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_dout",    dout_l,  4'h0);
    check("rst_valid",   valid_l, 1'b0);
    check("rst_overrun", ovr_l,   1'b0);
    check("rst_bit_cnt", cnt_l,   2'd0);
    check("rst_busy",    busy_l,  1'b0);
    check("rst_msb_dout", dout_m, 4'h0);

    // Reset mid-word
    clr_n = 1'b1;
    bit_step(1'b1); bit_step(1'b1); bit_step(1'b1);
    check("partial_cnt",  cnt_l,  2'd3);
    check("partial_busy", busy_l, 1'b1);
    clr_n = 1'b0; tick(); clr_n = 1'b1;
    check("midrst_cnt",   cnt_l,   2'd0);
    check("midrst_valid", valid_l, 1'b0);

    // LSB/MSB first, consecutive bits 0,1,0,1
    dout_ready = 1'b1;
    bit_step(1'b0); bit_step(1'b1); bit_step(1'b0);
    check("pre_valid", valid_l, 1'b0);
    bit_step(1'b1);
    check("lsb_valid", valid_l, 1'b1);
    check("lsb_dout",  dout_l,  4'b1010);
    check("msb_dout",  dout_m,  4'b0101);
    tick();
    check("accept_valid", valid_l, 1'b0);
    check("stale_dout",   dout_l,  4'b1010);

    // Gapped bit_en (1 of 3 clocks), X on sin while idle
    bit_step(1'b0); tick(); tick();
    bit_step(1'b1); tick(); tick();
    bit_step(1'b0); tick(); tick();
    bit_step(1'b1);
    check("gap_msb_valid", valid_m, 1'b1);
    check("gap_msb_dout",  dout_m,  4'b0101);
    check("gap_lsb_dout",  dout_l,  4'b1010);
    tick();

    // Back-pressure and overrun
    dout_ready = 1'b0;
    send_word(4'hA);
    check("bp_valid", valid_l, 1'b1);
    send_word(4'h5);
    check("bp_dout",    dout_l, 4'hA);
    check("bp_overrun", ovr_l,  1'b1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_clr", ovr_l, 1'b0);
    ovr_clr = 1'b1;
    send_word(4'h5);
    ovr_clr = 1'b0;
    check("ovr_set_prio", ovr_l, 1'b1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_clr2", ovr_l, 1'b0);
    dout_ready = 1'b1; tick();
    check("drain_valid", valid_l, 1'b0);
    check("drain_dout",  dout_l,  4'hA);

    // Back-to-back words, ready only at the second completion edge
    send_word(4'hA);
    check("b2b_first", dout_l, 4'hA);
    dout_ready = 1'b0;
    bit_step(1'b1);
    check("b2b_hold1", valid_l, 1'b1);
    bit_step(1'b1);
    check("b2b_hold2", valid_l, 1'b1);
    bit_step(1'b0);
    check("b2b_hold3", valid_l, 1'b1);
    dout_ready = 1'b1;
    bit_step(1'b0);
    check("b2b_valid",   valid_l, 1'b1);
    check("b2b_dout",    dout_l,  4'h3);
    check("b2b_overrun", ovr_l,   1'b0);
    tick();
    check("b2b_drain", valid_l, 1'b0);

    // Sync with a coinciding bit restarts the word
    bit_step(1'b1); bit_step(1'b0);
    sync = 1'b1; bit_step(1'b1); sync = 1'b0;
    check("sync_cnt", cnt_l, 2'd1);
    bit_step(1'b1); bit_step(1'b1);
    dout_ready = 1'b0;
    bit_step(1'b0);
    check("sync_dout",  dout_l,  4'b0111);
    check("sync_valid", valid_l, 1'b1);

    // Sync on the 4th bit cancels completion
    bit_step(1'b1); bit_step(1'b0); bit_step(1'b1);
    sync = 1'b1; bit_step(1'b1); sync = 1'b0;
    check("cancel_dout",    dout_l,  4'b0111);
    check("cancel_valid",   valid_l, 1'b1);
    check("cancel_overrun", ovr_l,   1'b0);
    check("cancel_cnt",     cnt_l,   2'd1);
    sync = 1'b1; tick(); sync = 1'b0;
    check("sync_idle_cnt",  cnt_l,  2'd0);
    check("sync_idle_busy", busy_l, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
